// File: rtl/button_reader.sv
// button_reader: synchronize, debounce and classify a push-button into event strobes.
// Ports: clk (27 MHz), rst (sync, active-high), btn_in (raw async pin),
//        btn_level (debounced, 1 = pressed), press_pulse / release_pulse /
//        long_pulse / repeat_pulse (one-cycle strobes), press_count (16-bit, wraps).
// Optional feature: define BTN_REPEAT_EN to enable auto-repeat while held.
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int LONG_CYCLES     = 27_000_000,
    parameter int REPEAT_CYCLES   = 6_750_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_in,
    output logic        btn_level,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic        long_pulse,
    output logic        repeat_pulse,
    output logic [15:0] press_count
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW = $clog2(HMAX + 1);
    localparam logic REL = ACTIVE_LOW != 0;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] HELD = 2'd2;
    logic          s1, s2, s, settle, rise, fall;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hold;
    logic [1:0]    state;
    always_comb begin
        s = REL ? ~s2 : s2;
        settle = (s != btn_level) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
        rise = settle && s;
        fall = settle && !s;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= REL;
            s2 <= REL;
            dcnt <= '0;
            btn_level <= 1'b0;
            state <= IDLE;
            hold <= '0;
            press_pulse <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse <= 1'b0;
            press_count <= '0;
`ifdef BTN_REPEAT_EN
            repeat_pulse <= 1'b0;
`endif
        end else begin
            s1 <= btn_in;
            s2 <= s1;
            dcnt <= (s == btn_level || settle) ? '0 : dcnt + 1'b1;
            if (settle)
                btn_level <= s;
            press_pulse <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse <= 1'b0;
`ifdef BTN_REPEAT_EN
            repeat_pulse <= 1'b0;
`endif
            // a release always wins over a long/repeat limit on the same edge
            if (fall) begin
                state <= IDLE;
                release_pulse <= 1'b1;
                hold <= '0;
            end else if (state == IDLE) begin
                if (rise) begin
                    state <= PRESSED;
                    press_pulse <= 1'b1;
                    hold <= '0;
                    press_count <= press_count + 1'b1;
                end
            end else if (state == PRESSED) begin
                if (hold == HW'(LONG_CYCLES - 1)) begin
                    state <= HELD;
                    long_pulse <= 1'b1;
                    hold <= '0;
                end else begin
                    hold <= hold + 1'b1;
                end
            end else begin
`ifdef BTN_REPEAT_EN
                if (hold == HW'(REPEAT_CYCLES - 1)) begin
                    repeat_pulse <= 1'b1;
                    hold <= '0;
                end else begin
                    hold <= hold + 1'b1;
                end
`endif
            end
        end
    end
`ifndef BTN_REPEAT_EN
    assign repeat_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: scoreboard bench for button_reader with short debounce/long/repeat windows.
module tb_button_reader;
    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;
    logic        clk, rst, btn_in;
    logic        btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic [15:0] press_count;
    logic [15:0] exp_count;
    int          total, bad, cyc;
    int          q[$];
    int          mon_n, mon_code, mon_e;

    button_reader #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .REPEAT_CYCLES(R),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event codes: 0 press, 1 release, 2 long, 3 repeat; entries are cycle*4+code
    always @(negedge clk) begin
        mon_n = 0;
        mon_code = 0;
        if (repeat_pulse === 1'b1) begin mon_n++; mon_code = 3; end
        if (long_pulse === 1'b1) begin mon_n++; mon_code = 2; end
        if (release_pulse === 1'b1) begin mon_n++; mon_code = 1; end
        if (press_pulse === 1'b1) begin mon_n++; mon_code = 0; end
        if (mon_n != 0) begin
            total++;
            if (mon_n > 1) begin
                bad++;
                $display("FAIL strobe_exclusive cycle=%0d strobes_high=%0d required=1", cyc, mon_n);
            end else if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cycle=%0d code=%0d required=none", cyc, mon_code);
            end else begin
                mon_e = q.pop_front();
                if (mon_e !== cyc * 4 + mon_code) begin
                    bad++;
                    $display("FAIL event got cycle=%0d code=%0d required cycle=%0d code=%0d",
                             cyc, mon_code, mon_e / 4, mon_e % 4);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(int c, int t);
        q.push_back(c * 4 + t);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_in = 1'b1;
        tick(3);
        total++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b required=00000",
                     {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
        total++;
        if (press_count !== 16'h0000) begin
            bad++;
            $display("FAIL reset_count got=%h required=0000", press_count);
        end
        rst = 1'b0;
        exp_count = 16'h0000;
        tick(2);
    endtask

    task automatic test_clean_press();
        int n;
        n = cyc;
        btn_in = 1'b0;
        expect_ev(n + D + 2, 0);
        exp_count++;
        tick(D + 2);
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL clean_level_pressed got=%b required=1", btn_level);
        end
        total++;
        if (press_count !== exp_count) begin
            bad++;
            $display("FAIL clean_count got=%h required=%h", press_count, exp_count);
        end
        tick(4);
        n = cyc;
        btn_in = 1'b1;
        expect_ev(n + D + 2, 1);
        tick(D + 2);
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL clean_level_released got=%b required=0", btn_level);
        end
        total++;
        if (press_count !== exp_count) begin
            bad++;
            $display("FAIL clean_count_after_release got=%h required=%h", press_count, exp_count);
        end
        tick(4);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b0;
            tick(3);
            btn_in = 1'b1;
            tick(1);
        end
        tick(12);
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL bounce_level got=%b required=0", btn_level);
        end
        total++;
        if (press_count !== exp_count) begin
            bad++;
            $display("FAIL bounce_count got=%h required=%h", press_count, exp_count);
        end
    endtask

    task automatic test_long_repeat();
        int n, p;
        n = cyc;
        p = n + D + 2;
        btn_in = 1'b0;
        expect_ev(p, 0);
        expect_ev(p + L, 2);
`ifdef BTN_REPEAT_EN
        for (int k = 1; L + k * R < 60; k++)
            expect_ev(p + L + k * R, 3);
`endif
        expect_ev(p + 60, 1);
        exp_count++;
        tick(D + 2 + L);
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL long_level got=%b required=1", btn_level);
        end
        tick(60 - (D + 2 + L));
        btn_in = 1'b1;
        tick(D + 2 + 10);
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL long_level_released got=%b required=0", btn_level);
        end
        total++;
        if (press_count !== exp_count) begin
            bad++;
            $display("FAIL long_count got=%h required=%h", press_count, exp_count);
        end
    endtask

    task automatic test_release_at_long();
        int n;
        n = cyc;
        btn_in = 1'b0;
        expect_ev(n + D + 2, 0);
        expect_ev(n + D + 2 + L, 1);
        exp_count++;
        tick(L);
        btn_in = 1'b1;
        tick(D + 2 + 4);
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL edge_level got=%b required=0", btn_level);
        end
        total++;
        if (press_count !== exp_count) begin
            bad++;
            $display("FAIL edge_count got=%h required=%h", press_count, exp_count);
        end
    endtask

    task automatic test_reset_mid_press();
        int n;
        n = cyc;
        btn_in = 1'b0;
        expect_ev(n + D + 2, 0);
        exp_count++;
        tick(D + 2 + 3);
        rst = 1'b1;
        tick(2);
        total++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 5'b0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b required=00000",
                     {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
        total++;
        if (press_count !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_count got=%h required=0000", press_count);
        end
        exp_count = 16'h0000;
        rst = 1'b0;
        n = cyc;
        expect_ev(n + D + 2, 0);
        exp_count++;
        tick(D + 2);
        total++;
        if (press_count !== exp_count) begin
            bad++;
            $display("FAIL midreset_repress_count got=%h required=%h", press_count, exp_count);
        end
        tick(3);
        n = cyc;
        btn_in = 1'b1;
        expect_ev(n + D + 2, 1);
        tick(D + 2 + 4);
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 0; i < 3; i++) begin
            n = cyc;
            btn_in = 1'b0;
            expect_ev(n + D + 2, 0);
            expect_ev(n + 8 + D + 2, 1);
            exp_count++;
            tick(8);
            btn_in = 1'b1;
            tick(8);
        end
        tick(4);
        total++;
        if (press_count !== exp_count) begin
            bad++;
            $display("FAIL b2b_count got=%h required=%h", press_count, exp_count);
        end
    endtask

    task automatic test_wrap();
        int n;
        force dut.press_count = 16'hFFFF;
        tick(1);
        release dut.press_count;
        exp_count = 16'hFFFF;
        tick(1);
        total++;
        if (press_count !== exp_count) begin
            bad++;
            $display("FAIL wrap_preload got=%h required=%h", press_count, exp_count);
        end
        n = cyc;
        btn_in = 1'b0;
        expect_ev(n + D + 2, 0);
        exp_count++;
        tick(D + 2);
        total++;
        if (press_count !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_count got=%h required=0000", press_count);
        end
        tick(2);
        n = cyc;
        btn_in = 1'b1;
        expect_ev(n + D + 2, 1);
        tick(D + 2 + 4);
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_count = 16'h0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_release_at_long();
        test_reset_mid_press();
        test_back_to_back();
        test_wrap();
        tick(30);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_events got=%0d pending required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
